pwm_gen_multi: RTL and testbench

//  Multi-channel, parametrised PWM generator driving motor/actuator outputs from the AXI register slave.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_prescaler.sv | 41 ++++
 rtl/pwm_gen_multi.sv | 160 ++++++++++++++++
 tb/tb_pwm_gen_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Purpose : shared constants and types for the multi-channel PWM generator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int CH_NUM_DEF  = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int PRESC_W_DEF = 8;

    // Counting mode, latched at each period boundary from i_center.
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Counter direction; only centre mode ever counts down.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Purpose : tick-enable generator, one tick every i_presc+1 clocks while enabled.
// Latency : combinational tick from the registered divider count.
// Backpressure: none; free-running while i_enable is high, held at 0 when low.
//
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_enable        run; low holds the divider at 0 so the first enabled clock
//                   starts a fresh count
//   i_presc         divide value (tick every i_presc+1 clocks)
//   o_tick          single-clock enable pulse
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_presc_cnt;
    logic               w_wrap;

    // '>=' rather than '==' so a live decrease of i_presc below the current
    // count wraps immediately instead of running all the way round.
    assign w_wrap = (r_presc_cnt >= i_presc);
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc_cnt <= '0;
        end else if (!i_enable || w_wrap) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_gen_multi.sv
// Purpose : multi-channel PWM, shared prescaler/period counter, per-channel
//           double-buffered compare and polarity, edge- or centre-aligned.
// Latency : o_pwm and o_period_end are registered, one clock after o_cnt.
// Backpressure: none; outputs free-run, i_load is a single-cycle strobe.
//
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_enable        run counter; low = idle (outputs at inactive level)
//   i_presc         tick every i_presc+1 clocks
//   i_top           period top value (taken at period boundaries)
//   i_center        0 = edge-aligned, 1 = centre-aligned (taken at boundaries)
//   i_pol           per-channel output inversion
//   i_ocr           compare values, channel n = [n*CNT_W +: CNT_W]
//   i_load          strobe: capture i_ocr into the shadow registers
//   o_pwm           PWM outputs
//   o_period_end    one-clock pulse after each period boundary
//   o_cnt           current counter value
module pwm_gen_multi
    import pwm_pkg::*;
#(
    parameter int CH_NUM  = CH_NUM_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [PRESC_W-1:0]      i_presc,
    input  logic [CNT_W-1:0]        i_top,
    input  logic                    i_center,
    input  logic [CH_NUM-1:0]       i_pol,
    input  logic [CH_NUM*CNT_W-1:0] i_ocr,
    input  logic                    i_load,
    output logic [CH_NUM-1:0]       o_pwm,
    output logic                    o_period_end,
    output logic [CNT_W-1:0]        o_cnt
);

    logic             w_tick;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    dir_e             r_dir;
    dir_e             w_dir_nxt;
    logic [CNT_W-1:0] r_act_top;
    logic             r_act_mode;
    logic             r_pending;
    logic             r_period_end;
    logic             w_boundary;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_presc  (i_presc),
        .o_tick   (w_tick)
    );

    // Next counter value, applied only on a tick. All comparisons use the
    // latched top so a mid-period i_top change cannot shorten the period.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (r_act_mode == MODE_EDGE) begin
            w_dir_nxt = DIR_UP;
            w_cnt_nxt = (r_cnt >= r_act_top) ? '0 : r_cnt + 1'b1;
        end else if (r_act_top == '0) begin
            w_dir_nxt = DIR_UP;
            w_cnt_nxt = '0;
        end else if ((r_dir == DIR_UP) && (r_cnt < r_act_top)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            // At top, or already descending. Reaching 0 turns back up, so 0
            // and top are each visited once per 2*top-tick period.
            w_cnt_nxt = r_cnt - 1'b1;
            w_dir_nxt = (r_cnt == CNT_W'(1)) ? DIR_UP : DIR_DOWN;
        end
    end

    // A period ends on the tick that lands on 0 from a nonzero value, or on
    // every tick when the counter is parked at 0 by top == 0.
    assign w_boundary = w_tick && (w_cnt_nxt == '0) &&
                        ((r_cnt != '0) || (r_act_top == '0));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_dir        <= DIR_UP;
            r_act_top    <= '0;
            r_act_mode   <= MODE_EDGE;
            r_pending    <= 1'b0;
            r_period_end <= 1'b0;
        end else if (!i_enable) begin
            // Idle: track the inputs so the first tick after enable starts a
            // clean period with the latest configuration.
            r_cnt        <= '0;
            r_dir        <= DIR_UP;
            r_act_top    <= i_top;
            r_act_mode   <= i_center;
            r_pending    <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_period_end <= w_boundary;
            if (w_tick) begin
                r_cnt <= w_cnt_nxt;
                r_dir <= w_dir_nxt;
            end
            if (w_boundary) begin
                r_act_top  <= i_top;
                r_act_mode <= i_center;
                r_pending  <= 1'b0;
            end else if (i_load) begin
                r_pending  <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic [CNT_W-1:0] w_ocr_in;
        logic [CNT_W-1:0] r_shadow;
        logic [CNT_W-1:0] r_act_ocr;
        logic             r_pwm;

        assign w_ocr_in = i_ocr[n*CNT_W +: CNT_W];

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_shadow  <= '0;
                r_act_ocr <= '0;
                r_pwm     <= 1'b0;
            end else begin
                if (i_load) begin
                    r_shadow <= w_ocr_in;
                end
                if (!i_enable) begin
                    r_act_ocr <= i_load ? w_ocr_in : r_shadow;
                    r_pwm     <= i_pol[n];
                end else begin
                    // A load on the boundary itself bypasses the shadow so it
                    // governs the period that starts here.
                    if (w_boundary) begin
                        if (i_load) begin
                            r_act_ocr <= w_ocr_in;
                        end else if (r_pending) begin
                            r_act_ocr <= r_shadow;
                        end
                    end
                    r_pwm <= (r_cnt < r_act_ocr) ^ i_pol[n];
                end
            end
        end

        assign o_pwm[n] = r_pwm;
    end

    assign o_period_end = r_period_end;
    assign o_cnt        = r_cnt;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Purpose : self-checking bench for pwm_gen_multi (CH_NUM=4, CNT_W=8).
// Latency : n/a.
// Backpressure: n/a.
module tb_pwm_gen_multi;

    logic        clk;
    logic        i_reset;
    logic        i_enable;
    logic [7:0]  i_presc;
    logic [7:0]  i_top;
    logic        i_center;
    logic [3:0]  i_pol;
    logic [31:0] i_ocr;
    logic        i_load;
    logic [3:0]  o_pwm;
    logic        o_period_end;
    logic [7:0]  o_cnt;

    pwm_gen_multi #(
        .CH_NUM  (4),
        .CNT_W   (8),
        .PRESC_W (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_presc      (i_presc),
        .i_top        (i_top),
        .i_center     (i_center),
        .i_pol        (i_pol),
        .i_ocr        (i_ocr),
        .i_load       (i_load),
        .o_pwm        (o_pwm),
        .o_period_end (o_period_end),
        .o_cnt        (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result of one measured period window.
    typedef struct packed {
        logic [15:0]       period;
        logic [3:0][15:0]  high;
    } exp_t;

    typedef struct packed {
        logic [7:0]  top;
        logic [7:0]  presc;
        logic        center;
        logic [3:0]  pol;
        logic [31:0] ocr;
        exp_t        exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_rise0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int per, input int h0, input int h1,
                                    input int h2, input int h3);
        exp_t e;
        e.period  = 16'(per);
        e.high[0] = 16'(h0);
        e.high[1] = 16'(h1);
        e.high[2] = 16'(h2);
        e.high[3] = 16'(h3);
        return e;
    endfunction

    function automatic vec_t mk(input int top, input int presc, input int center,
                                input int pol, input int o0, input int o1,
                                input int o2, input int o3, input exp_t e);
        vec_t v;
        v.top    = 8'(top);
        v.presc  = 8'(presc);
        v.center = 1'(center);
        v.pol    = 4'(pol);
        v.ocr    = {8'(o3), 8'(o2), 8'(o1), 8'(o0)};
        v.exp    = e;
        return v;
    endfunction

    // Reconfigure while idle: load compare values straight into the active
    // registers, then enable.
    task automatic cfg(input logic [7:0] top, input logic [7:0] presc,
                       input logic center, input logic [3:0] pol,
                       input logic [31:0] ocr);
        i_enable = 1'b0;
        i_top    = top;
        i_presc  = presc;
        i_center = center;
        i_pol    = pol;
        i_ocr    = ocr;
        i_load   = 1'b1;
        @(negedge clk);
        i_load   = 1'b0;
        @(negedge clk);
        i_enable = 1'b1;
    endtask

    // Wait for a period_end, then accumulate high clocks per channel until the
    // next one. Optionally pulses i_load when o_cnt reaches load_at.
    // Pops the expected record and compares.
    task automatic measure(input string tag, input int load_at,
                           input logic [31:0] load_val);
        int   waited;
        int   per;
        int   hi[4];
        bit   loaded;
        logic prev0;
        exp_t e;
        waited = 0;
        while (o_period_end !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_start_timeout"}, int'(waited >= 3000), 0);
        per     = 0;
        loaded  = 0;
        m_rise0 = 0;
        prev0   = o_pwm[0];
        for (int c = 0; c < 4; c++) hi[c] = 0;
        do begin
            if (i_load) i_load = 1'b0;
            for (int c = 0; c < 4; c++) if (o_pwm[c] === 1'b1) hi[c]++;
            if (o_pwm[0] === 1'b1 && prev0 === 1'b0) m_rise0++;
            prev0 = o_pwm[0];
            if (load_at >= 0 && !loaded && int'(o_cnt) == load_at) begin
                i_ocr  = load_val;
                i_load = 1'b1;
                loaded = 1;
            end
            @(negedge clk);
            per++;
        end while (o_period_end !== 1'b1 && per < 3000);
        i_load = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_queue: got empty scoreboard, expected a record", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_period"}, per, int'(e.period));
            for (int c = 0; c < 4; c++)
                check($sformatf("%s_high%0d", tag, c), hi[c], int'(e.high[c]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Centre, top=50: visits 0..50 then 49..1 (100 ticks). cnt<ocr holds
        // for ocr values on the way up and ocr-1 on the way down, i.e.
        // 2*ocr-1 ticks, times presc+1 = 2 clocks.
        vecs[0] = mk(99, 0, 0, 4'b1000, 25, 0, 255, 25, mk_exp(100, 25, 0, 100, 75));
        vecs[1] = mk(9, 2, 0, 4'b0000, 5, 10, 1, 3, mk_exp(30, 15, 30, 3, 9));
        vecs[2] = mk(50, 1, 1, 4'b0000, 10, 0, 51, 50, mk_exp(200, 38, 0, 200, 198));
        vecs[3] = mk(0, 3, 0, 4'b1000, 1, 0, 2, 1, mk_exp(4, 4, 0, 4, 0));
        vecs[4] = mk(1, 0, 1, 4'b0001, 1, 2, 0, 1, mk_exp(2, 1, 2, 0, 1));

        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_presc  = '0;
        i_top    = '0;
        i_center = 1'b0;
        i_pol    = '0;
        i_ocr    = '0;
        i_load   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(o_pwm), 0);
        check("rst_period_end", int'(o_period_end), 0);
        check("rst_cnt", int'(o_cnt), 0);
        i_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            cfg(vecs[i].top, vecs[i].presc, vecs[i].center, vecs[i].pol, vecs[i].ocr);
            exp_q.push_back(vecs[i].exp);
            measure($sformatf("vec%0d", i), -1, '0);
        end

        // Mid-period load: current period keeps 25, next gets 75, one pulse.
        cfg(8'd99, 8'd0, 1'b0, 4'b0000, {8'd25, 8'd255, 8'd0, 8'd25});
        exp_q.push_back(mk_exp(100, 25, 0, 100, 25));
        measure("midload", 40, {8'd25, 8'd255, 8'd0, 8'd75});
        check("midload_rises", m_rise0, 1);
        exp_q.push_back(mk_exp(100, 75, 0, 100, 25));
        measure("after_midload", -1, '0);

        // Load on the boundary cycle: takes effect in the period that starts there.
        exp_q.push_back(mk_exp(100, 75, 0, 100, 25));
        measure("bndload", 99, {8'd25, 8'd255, 8'd0, 8'd50});
        exp_q.push_back(mk_exp(100, 50, 0, 100, 25));
        measure("after_bndload", -1, '0);

        // Asynchronous reset in the middle of a high pulse.
        @(negedge clk);
        check("pre_reset_high", int'(o_pwm[0]), 1);
        i_reset = 1'b1;
        #1;
        check("async_rst_pwm", int'(o_pwm), 0);
        check("async_rst_cnt", int'(o_cnt), 0);
        i_enable = 1'b0;
        i_pol    = 4'b1010;
        i_top    = 8'd9;
        i_presc  = 8'd2;
        i_center = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_pwm_pol", int'(o_pwm), 4'b1010);
        check("idle_period_end", int'(o_period_end), 0);
        check("idle_cnt", int'(o_cnt), 0);

        // Re-enable: first period_end after (top+1)*(presc+1) = 30 clocks.
        i_enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_period_end !== 1'b1 && n < 200);
        check("reenable_first_period", n, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
